// File: rtl/lift_call_panel_if.sv
// Passenger request handshake between a call source and lift_call_panel.
// The master offers {pickup, dest} with req_valid; the slave answers with req_ready.
interface lift_call_panel_if;
    logic       req_valid;
    logic [2:0] req_pickup;
    logic [2:0] req_dest;
    logic       req_ready;

    modport master (output req_valid, output req_pickup, output req_dest, input req_ready);
    modport slave  (input req_valid, input req_pickup, input req_dest, output req_ready);
endinterface

// File: rtl/lift_call_panel.sv
// Lift call panel: queues passenger requests and issues them one at a time to the lift controller.
// Optional LIFT_CALL_MERGE_EN: drop requests identical to a queued or in-service entry.
module lift_call_panel #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    lift_call_panel_if.slave        req_if,
    input  logic [2:0]              elev_f_i,
    input  logic                    busy_i,
    output logic [2:0]              pass_f,
    output logic [2:0]              butt_el,
    output logic                    butt_up_down,
    output logic [7:0]              call_lamp,
    output logic [3:0]              q_count,
    output logic                    err_timeout
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;
    typedef struct packed {
        logic [2:0] pickup;
        logic [2:0] dest;
    } entry_t;

    state_t          state_q;
    entry_t          svc_q;
    entry_t          mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [3:0]      count_q, count_d;
    logic            ready_q, strobe_q, err_q;
    logic [2:0]      pass_q, el_q;
    logic [7:0]      lamp_q, lamp_d;
    logic [TW-1:0]   timer_q;

    entry_t          req_e;
    logic            push_hs, store, pop, complete, timeout, release_svc, merge;
    logic            dup_q;
    logic [7:0]      queued_mask;

    assign req_e   = '{pickup: req_if.req_pickup, dest: req_if.req_dest};
    assign push_hs = req_if.req_valid && ready_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        queued_mask = '0;
        dup_q       = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (k < int'(count_q)) begin
                queued_mask[mem_q[rd_ptr_q + PW'(k)].pickup] = 1'b1;
                if (mem_q[rd_ptr_q + PW'(k)] == req_e) dup_q = 1'b1;
            end
        end
    end

    assign pop         = (state_q == IDLE) && (count_q != 4'd0) && !busy_i;
    assign complete    = (state_q == WAIT_DONE) && !busy_i && (elev_f_i == svc_q.dest);
    assign timeout     = (state_q == WAIT_ACK) && !busy_i && (timer_q == TW'(ACK_TIMEOUT - 1));
    assign release_svc = complete || timeout;

`ifdef LIFT_CALL_MERGE_EN
    // A service entry finishing this edge no longer absorbs duplicates.
    assign merge = dup_q || ((state_q != IDLE) && !release_svc && (svc_q == req_e));
`else
    assign merge = 1'b0;
`endif

    assign store   = push_hs && !merge;
    assign count_d = count_q + 4'(store) - 4'(pop);

    always_comb begin
        lamp_d = lamp_q;
        if (release_svc) lamp_d[svc_q.pickup] = queued_mask[svc_q.pickup];
        if (push_hs)     lamp_d[req_e.pickup] = 1'b1;
    end

    // NOTE: queue storage has no reset; only pointers and count define which slots are valid.
    always_ff @(posedge clk) begin
        if (store) mem_q[wr_ptr_q] <= req_e;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            svc_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            strobe_q <= 1'b0;
            pass_q   <= '0;
            el_q     <= '0;
            lamp_q   <= '0;
            err_q    <= 1'b0;
            timer_q  <= '0;
        end else begin
            ready_q  <= (count_d < 4'(FIFO_DEPTH));
            count_q  <= count_d;
            lamp_q   <= lamp_d;
            strobe_q <= 1'b0;
            if (store) wr_ptr_q <= wr_ptr_q + PW'(1);
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        svc_q    <= mem_q[rd_ptr_q];
                        pass_q   <= mem_q[rd_ptr_q].pickup;
                        el_q     <= mem_q[rd_ptr_q].dest;
                        rd_ptr_q <= rd_ptr_q + PW'(1);
                        strobe_q <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (busy_i) begin
                        timer_q <= '0;
                        state_q <= WAIT_DONE;
                    end else if (timeout) begin
                        timer_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (complete) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.req_ready = ready_q;
    assign pass_f           = pass_q;
    assign butt_el          = el_q;
    assign butt_up_down     = strobe_q;
    assign call_lamp        = lamp_q;
    assign q_count          = count_q;
    assign err_timeout      = err_q;
endmodule

// File: tb/tb_lift_call_panel.sv
// Scoreboard bench for lift_call_panel: accepted requests are queued as expected strobes.
module tb_lift_call_panel;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] elev_f_i;
    logic       busy_i;
    logic [2:0] pass_f, butt_el;
    logic       butt_up_down, err_timeout;
    logic [7:0] call_lamp;
    logic [3:0] q_count;

    always #5 clk = ~clk;

    lift_call_panel_if req_if ();

    lift_call_panel #(.FIFO_DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if),
        .elev_f_i     (elev_f_i),
        .busy_i       (busy_i),
        .pass_f       (pass_f),
        .butt_el      (butt_el),
        .butt_up_down (butt_up_down),
        .call_lamp    (call_lamp),
        .q_count      (q_count),
        .err_timeout  (err_timeout)
    );

`ifdef LIFT_CALL_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] p;
        logic [2:0] d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_strobe = 0;
    bit         prev_strobe = 1'b0;
    bit         model_en = 1'b0;
    logic [2:0] model_dest;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every strobe must match the oldest accepted request and never repeat back to back.
    always @(negedge clk) begin
        if (!rst && butt_up_down) begin
            n_strobe++;
            check("strobe_gap", prev_strobe, 0);
            if (exp_q.size() == 0) begin
                check("strobe_unexpected", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("pass_f", pass_f, mon_e.p);
                check("butt_el", butt_el, mon_e.d);
            end
        end
        prev_strobe = butt_up_down;
    end

    // Lift model: busy 3 cycles after the strobe, arrive at the destination 2 cycles later.
    initial forever begin
        @(negedge clk);
        if (model_en && butt_up_down) begin
            model_dest = butt_el;
            repeat (3) @(negedge clk);
            busy_i = 1'b1;
            repeat (2) @(negedge clk);
            elev_f_i = model_dest;
            busy_i   = 1'b0;
        end
    end

    task automatic send(input logic [2:0] p, input logic [2:0] d, input bit store, output bit acc);
        @(negedge clk);
        req_if.req_valid  = 1'b1;
        req_if.req_pickup = p;
        req_if.req_dest   = d;
        acc = req_if.req_ready;
        if (acc && store) exp_q.push_back(exp_t'{p: p, d: d});
        @(posedge clk);
        #1 req_if.req_valid = 1'b0;
    endtask

    task automatic wait_strobe(input string tag, input int exp_delay);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!butt_up_down && n < 40);
        check(tag, n, exp_delay);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(exp_q.size() == 0 && q_count == 4'd0 && call_lamp == 8'h00 && busy_i == 1'b0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, n < 300, 1);
    endtask

    initial begin
        bit         acc;
        int         n, s0;
        logic [2:0] fp [5];
        logic [2:0] fd [5];
        fp = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd6};
        fd = '{3'd1, 3'd3, 3'd5, 3'd0, 3'd6};

        rst = 1'b1;
        req_if.req_valid = 1'b0; req_if.req_pickup = '0; req_if.req_dest = '0;
        busy_i = 1'b0; elev_f_i = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_if.req_ready, 0);
        check("rst_qcount", q_count, 0);
        check("rst_strobe", butt_up_down, 0);
        check("rst_pass_f", pass_f, 0);
        check("rst_butt_el", butt_el, 0);
        check("rst_lamp", call_lamp, 0);
        check("rst_err", err_timeout, 0);
        rst = 1'b0;
        #1 check("ready_before_edge", req_if.req_ready, 0);
        @(negedge clk);
        check("ready_after_rst", req_if.req_ready, 1);

        // Single request into an empty panel, then a second queued behind it.
        send(3'd3, 3'd7, 1'b1, acc);
        check("acc_3_7", acc, 1);
        wait_strobe("lat_3_7", 2);
        check("lamp_3_7", call_lamp, 8'h08);
        check("q_after_issue", q_count, 0);
        send(3'd1, 3'd4, 1'b1, acc);
        repeat (2) @(negedge clk);
        busy_i = 1'b1;
        check("q_one_waiting", q_count, 1);
        check("lamp_two", call_lamp, 8'h0A);
        repeat (2) @(negedge clk);
        elev_f_i = 3'd7;
        busy_i   = 1'b0;
        @(negedge clk);
        check("lamp_after_done", call_lamp, 8'h02);
        check("no_strobe_in_idle", butt_up_down, 0);
        wait_strobe("next_issue", 1);

        // Lift never answers {1,4}: timeout after 16 WAIT_ACK cycles.
        send(3'd6, 3'd2, 1'b1, acc);
        n = 1;
        while (!err_timeout && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, 17);
        check("lamp_after_timeout", call_lamp, 8'h40);
        wait_strobe("issue_after_timeout", 1);
        repeat (2) @(negedge clk);
        busy_i = 1'b1;
        repeat (2) @(negedge clk);
        elev_f_i = 3'd2;
        busy_i   = 1'b0;
        repeat (2) @(negedge clk);
        check("lamp_clear_6_2", call_lamp, 8'h00);
        check("err_sticky", err_timeout, 1);

        // Fill the queue while the lift is busy.
        busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(fp[i], fd[i], 1'b1, acc);
            check("full_acc", acc, (i < 4));
        end
        @(negedge clk);
        check("full_qcount", q_count, 4);
        check("full_ready", req_if.req_ready, 0);
        check("full_lamp", call_lamp, 8'h35);
        s0 = n_strobe;
        busy_i   = 1'b0;
        model_en = 1'b1;
        drain("drain_full");
        check("full_strobes", n_strobe - s0, 4);

        // Duplicate requests; the second is accepted on the same edge the first is popped.
        s0 = n_strobe;
        send(3'd2, 3'd5, 1'b1, acc);
        send(3'd2, 3'd5, !MERGE, acc);
        check("dup_acc", acc, 1);
        @(negedge clk);
        check("dup_qcount", q_count, MERGE ? 0 : 1);
        drain("drain_dup");
        check("dup_strobes", n_strobe - s0, MERGE ? 1 : 2);

        // Reset while the lift is carrying {1,6}, with {7,7} still queued.
        model_en = 1'b0;
        busy_i   = 1'b0;
        send(3'd1, 3'd6, 1'b1, acc);
        send(3'd7, 3'd7, 1'b1, acc);
        wait_strobe("issue_1_6", 1);
        @(negedge clk);
        busy_i = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_strobe", butt_up_down, 0);
        check("midrst_pass_f", pass_f, 0);
        check("midrst_butt_el", butt_el, 0);
        check("midrst_lamp", call_lamp, 0);
        check("midrst_qcount", q_count, 0);
        check("midrst_err", err_timeout, 0);
        check("midrst_ready", req_if.req_ready, 0);
        exp_q.delete();
        busy_i = 1'b0;
        s0 = n_strobe;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_no_strobe", n_strobe - s0, 0);
        check("midrst_ready_back", req_if.req_ready, 1);

        // Pickup equals destination after reset.
        model_en = 1'b1;
        send(3'd7, 3'd7, 1'b1, acc);
        check("acc_7_7", acc, 1);
        wait_strobe("lat_7_7", 2);
        drain("drain_7_7");
        check("final_qcount", q_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end
endmodule
